// File: rtl/mul_16bit_wallace.sv
// ---------------------------------------------------------------------------
// mul_16bit_wallace
//   Unsigned 16x16 multiplier. Operands are captured once after reset is
//   released, the 16 partial-product rows are compressed by a Wallace tree
//   in two registered stages (16->11->8->6, then 6->4->3->2), and a final
//   carry-propagate add forms the 32-bit product. The result and done flag
//   then hold until the next reset.
//
// Ports
//   i_clk    in   1   clock, rising edge
//   i_rst    in   1   synchronous active-high reset
//   i_num_a  in   16  multiplicand, unsigned
//   i_num_b  in   16  multiplier, unsigned
//   o_end    out  1   done; high while o_res/o_cry are valid
//   o_res    out  32  product i_num_a * i_num_b
//   o_cry    out  1   1 when o_res[31:16] != 0
// ---------------------------------------------------------------------------
module mul_16bit_wallace #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [DATA_WIDTH-1:0]     i_num_a,
    input  logic [DATA_WIDTH-1:0]     i_num_b,
    output logic                      o_end,
    output logic [2*DATA_WIDTH-1:0]   o_res,
    output logic                      o_cry
);

    typedef enum logic [2:0] {
        CAPT = 3'd0,
        RED1 = 3'd1,
        RED2 = 3'd2,
        ADD  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t      state;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [31:0] rows_q [6];
    logic [31:0] sum_q;
    logic [31:0] car_q;

    logic [31:0] lv0 [16];
    logic [31:0] lv1 [11];
    logic [31:0] lv2 [8];
    logic [31:0] lv3 [6];
    logic [31:0] lv4 [4];
    logic [31:0] lv5 [3];
    logic [31:0] lv6 [2];
    logic [31:0] prod;

    // One row-wide bank of full adders: {carry row, sum row}. Bit positions
    // whose third input is zero degenerate to half adders. The carry row is
    // shifted one weight up; its bit 31 is provably zero because the total
    // of all rows never exceeds 32 bits.
    function automatic logic [63:0] csa(input logic [31:0] x,
                                        input logic [31:0] y,
                                        input logic [31:0] z);
        logic [31:0] s;
        logic [31:0] c;
        s = x ^ y ^ z;
        c = ((x & y) | (x & z) | (y & z)) << 1;
        return {c, s};
    endfunction

    // Stage 1: partial products and Wallace levels 1-3 (16 -> 11 -> 8 -> 6).
    always_comb begin
        for (int unsigned j = 0; j < 16; j++) begin
            lv0[j] = {16'h0000, a_q & {16{b_q[j]}}} << j;
        end
        for (int unsigned g = 0; g < 5; g++) begin
            {lv1[2*g+1], lv1[2*g]} = csa(lv0[3*g], lv0[3*g+1], lv0[3*g+2]);
        end
        lv1[10] = lv0[15];
        for (int unsigned g = 0; g < 3; g++) begin
            {lv2[2*g+1], lv2[2*g]} = csa(lv1[3*g], lv1[3*g+1], lv1[3*g+2]);
        end
        lv2[6] = lv1[9];
        lv2[7] = lv1[10];
        for (int unsigned g = 0; g < 2; g++) begin
            {lv3[2*g+1], lv3[2*g]} = csa(lv2[3*g], lv2[3*g+1], lv2[3*g+2]);
        end
        lv3[4] = lv2[6];
        lv3[5] = lv2[7];
    end

    // Stage 2: Wallace levels 4-6 (6 -> 4 -> 3 -> 2) from the registered rows.
    always_comb begin
        {lv4[1], lv4[0]} = csa(rows_q[0], rows_q[1], rows_q[2]);
        {lv4[3], lv4[2]} = csa(rows_q[3], rows_q[4], rows_q[5]);
        {lv5[1], lv5[0]} = csa(lv4[0], lv4[1], lv4[2]);
        lv5[2]           = lv4[3];
        {lv6[1], lv6[0]} = csa(lv5[0], lv5[1], lv5[2]);
    end

    // Final carry-propagate add; the carry-out is always zero and dropped.
    assign prod = sum_q + car_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= CAPT;
            a_q   <= '0;
            b_q   <= '0;
            for (int unsigned i = 0; i < 6; i++) begin
                rows_q[i] <= '0;
            end
            sum_q <= '0;
            car_q <= '0;
            o_end <= 1'b0;
            o_res <= '0;
            o_cry <= 1'b0;
        end else begin
            case (state)
                CAPT: begin
                    a_q   <= i_num_a;
                    b_q   <= i_num_b;
                    state <= RED1;
                end
                RED1: begin
                    for (int unsigned i = 0; i < 6; i++) begin
                        rows_q[i] <= lv3[i];
                    end
                    state <= RED2;
                end
                RED2: begin
                    sum_q <= lv6[0];
                    car_q <= lv6[1];
                    state <= ADD;
                end
                ADD: begin
                    o_res <= prod;
                    o_cry <= |prod[31:16];
                    o_end <= 1'b1;
                    state <= DONE;
                end
                default: state <= DONE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_16bit_wallace.sv
// ---------------------------------------------------------------------------
// tb_mul_16bit_wallace
//   Directed and random checks of mul_16bit_wallace: reset state, latency,
//   result hold, reset re-issue, corner operands, operand changes after
//   capture, abort in the reduction stage, and a 1000-pair random sweep.
// ---------------------------------------------------------------------------
module tb_mul_16bit_wallace;

    logic        clk;
    logic        rst;
    logic [15:0] num_a;
    logic [15:0] num_b;
    logic        done;
    logic [31:0] res;
    logic        cry;

    int unsigned tests;
    int unsigned fails;

    mul_16bit_wallace #(.DATA_WIDTH(16)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_num_a (num_a),
        .i_num_b (num_b),
        .o_end   (done),
        .o_res   (res),
        .o_cry   (cry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse reset for one edge with the given operands, then release.
    // Returns at the falling edge just before the first edge with rst=0.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        rst   = 1'b1;
        num_a = a;
        num_b = b;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst   = 1'b1;
        num_a = 16'hBEEF;
        num_b = 16'h1234;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests++;
            if ({done, cry, res} !== 34'd0) begin
                fails++;
                $display("FAIL reset_hold cyc%0d: end=%b cry=%b res=%h, required 0 0 00000000",
                         i, done, cry, res);
            end
        end
    endtask

    task automatic test_basic();
        start_op(16'h000A, 16'h0009);
        repeat (3) @(negedge clk);
        tests++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL basic_early_end: got %b, required 0", done);
        end
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            tests++;
            if (done !== 1'b1 || res !== 32'h0000005A || cry !== 1'b0) begin
                fails++;
                $display("FAIL basic_hold cyc%0d: end=%b res=%h cry=%b, required 1 0000005a 0",
                         i, done, res, cry);
            end
            num_a = 16'hFFFF;
            num_b = 16'hFFFF;
            @(negedge clk);
        end
    endtask

    task automatic test_reissue();
        @(negedge clk);
        rst   = 1'b1;
        num_a = 16'h000A;
        num_b = 16'h0005;
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || res !== 32'd0) begin
            fails++;
            $display("FAIL reissue_clear: end=%b res=%h, required 0 00000000", done, res);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        tests++;
        if (done !== 1'b1 || res !== 32'h00000032 || cry !== 1'b0) begin
            fails++;
            $display("FAIL reissue_result: end=%b res=%h cry=%b, required 1 00000032 0",
                     done, res, cry);
        end
    endtask

    task automatic test_corners();
        logic [15:0] va [4];
        logic [15:0] vb [4];
        logic [31:0] vr [4];
        logic        vc [4];
        va = '{16'hFFFF, 16'h0000, 16'h0100, 16'h00FF};
        vb = '{16'hFFFF, 16'h1234, 16'h0100, 16'h0101};
        vr = '{32'hFFFE0001, 32'h00000000, 32'h00010000, 32'h0000FFFF};
        vc = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 4; k++) begin
            start_op(va[k], vb[k]);
            repeat (3) @(negedge clk);
            tests++;
            if (done !== 1'b0) begin
                fails++;
                $display("FAIL corner%0d_early_end: got %b, required 0", k, done);
            end
            @(negedge clk);
            tests++;
            if (done !== 1'b1 || res !== vr[k] || cry !== vc[k]) begin
                fails++;
                $display("FAIL corner%0d: end=%b res=%h cry=%b, required 1 %h %b",
                         k, done, res, cry, vr[k], vc[k]);
            end
        end
    endtask

    task automatic test_operand_change();
        start_op(16'h1234, 16'h5678);
        repeat (2) @(negedge clk);
        num_a = 16'hFFFF;
        num_b = 16'h0003;
        repeat (2) @(negedge clk);
        tests++;
        if (done !== 1'b1 || res !== 32'h06260060 || cry !== 1'b1) begin
            fails++;
            $display("FAIL operand_change: end=%b res=%h cry=%b, required 1 06260060 1",
                     done, res, cry);
        end
    endtask

    task automatic test_abort_red2();
        start_op(16'hFFFF, 16'hFFFF);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        num_a = 16'h0007;
        num_b = 16'h0006;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) rst = 1'b0;
            tests++;
            if (done !== 1'b0 || res !== 32'd0) begin
                fails++;
                $display("FAIL abort_no_end cyc%0d: end=%b res=%h, required 0 00000000",
                         i, done, res);
            end
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b1 || res !== 32'd42 || cry !== 1'b0) begin
            fails++;
            $display("FAIL abort_restart: end=%b res=%h cry=%b, required 1 0000002a 0",
                     done, res, cry);
        end
    endtask

    task automatic test_random();
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp_res;
        logic        exp_cry;
        for (int n = 0; n < 1000; n++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            exp_res = 32'(a) * 32'(b);
            exp_cry = (exp_res > 32'h0000FFFF);
            start_op(a, b);
            repeat (4) @(negedge clk);
            tests++;
            if (done !== 1'b1 || res !== exp_res || cry !== exp_cry) begin
                fails++;
                $display("FAIL random%0d a=%h b=%h: end=%b res=%h cry=%b, required 1 %h %b",
                         n, a, b, done, res, cry, exp_res, exp_cry);
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        num_a = '0;
        num_b = '0;
        test_reset();
        test_basic();
        test_reissue();
        test_corners();
        test_operand_change();
        test_abort_red2();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
